// File: rtl/xnor_conv_ctrl_pkg.sv
// Shared definitions for the XNOR convolution layer controller:
// FSM state encoding, column count and pointer rotation helper.
package xnor_conv_ctrl_pkg;

  localparam int COL_N       = 9;
  localparam int IMG_PIX_DEF = 1024;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_STREAM  = 3'd2,
    S_DRAIN   = 3'd3,
    S_NEXT_CH = 3'd4,
    S_FINISH  = 3'd5
  } state_e;

  // Rotate a one-hot column pointer one position toward the MSB, wrapping.
  function automatic logic [COL_N-1:0] rotl1(input logic [COL_N-1:0] v);
    return {v[COL_N-2:0], v[COL_N-1]};
  endfunction

endpackage

// File: rtl/xnor_col_ptr.sv
// Rotating one-hot column pointer: load forces bit0, advance rotates by one.
// Holds no bit set out of reset.
module xnor_col_ptr
  import xnor_conv_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  output logic [COL_N-1:0] ptr
);

  // Pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= {COL_N{1'b0}};
    end else if (load) begin
      ptr <= {{(COL_N-1){1'b0}}, 1'b1};
    end else if (advance) begin
      ptr <= rotl1(ptr);
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/xnor_conv_ctrl.sv
// Layer sequencer for the XNOR convolution core: per channel it loads one
// kernel, streams IMG_PIX pixels, drains the array, and steps the channel.
module xnor_conv_ctrl
  import xnor_conv_ctrl_pkg::*;
#(
  parameter int IMG_PIX   = IMG_PIX_DEF,
  parameter int ARRAY_LAT = 4,
  parameter int CH_W      = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [CH_W-1:0]  cfg_num_ch,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic             px_valid,
  output logic             px_ready,
  output logic             first_channel,
  output logic             last_channel,
  output logic             start,
  output logic             weight_control,
  output logic             start_threshold,
  output logic [COL_N-1:0] top_start,
  output logic [COL_N-1:0] top_control,
  output logic [COL_N-1:0] side_control,
  output logic             busy,
  output logic             done
);

  localparam int PIX_W = (IMG_PIX > 1) ? $clog2(IMG_PIX) : 1;
  localparam int DR_W  = $clog2(ARRAY_LAT + 3);

  state_e            state;
  state_e            state_nxt;
  logic [PIX_W-1:0]  pix_cnt;
  logic [DR_W-1:0]   drain_cnt;
  logic [CH_W-1:0]   ch_cnt;
  logic [CH_W-1:0]   num_ch;
  logic [CH_W-1:0]   ch_next;
  logic [COL_N-1:0]  ptr;
  logic              beat;
  logic              pix_last;
  logic              drain_last;
  logic              in_head;
  logic              in_layer;

  assign busy           = (state != S_IDLE);
  assign w_ready        = (state == S_LOAD_W);
  assign px_ready       = (state == S_STREAM);
  assign weight_control = w_ready & w_valid;
  assign beat           = px_ready & px_valid;
  assign start          = beat;
  assign pix_last       = (pix_cnt == PIX_W'(IMG_PIX - 1));
  assign drain_last     = (drain_cnt == DR_W'(ARRAY_LAT + 1));
  assign in_head        = (32'(pix_cnt) < 32'(COL_N));
  assign ch_next        = ch_cnt + CH_W'(1);

  // Pointer bits only reach the core on real beats; stalls present zero.
  assign top_control = beat ? ptr : {COL_N{1'b0}};
  assign top_start   = in_head ? top_control : {COL_N{1'b0}};

  assign in_layer        = (state == S_LOAD_W) || (state == S_STREAM) || (state == S_DRAIN);
  assign first_channel   = in_layer && (ch_cnt == {CH_W{1'b0}});
  assign last_channel    = in_layer && (ch_cnt == (num_ch - CH_W'(1)));
  assign start_threshold = last_channel && (state != S_LOAD_W);

  xnor_col_ptr u_col_ptr (
    .clk     (clk),
    .rst     (rst),
    .load    (w_ready),
    .advance (beat),
    .ptr     (ptr)
  );

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (cfg_start) state_nxt = S_LOAD_W; else state_nxt = S_IDLE;
      S_LOAD_W:  if (w_valid) state_nxt = S_STREAM; else state_nxt = S_LOAD_W;
      S_STREAM:  if (beat && pix_last) state_nxt = S_DRAIN; else state_nxt = S_STREAM;
      S_DRAIN:   if (drain_last) state_nxt = S_NEXT_CH; else state_nxt = S_DRAIN;
      S_NEXT_CH: if (ch_next == num_ch) state_nxt = S_FINISH; else state_nxt = S_LOAD_W;
      S_FINISH:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State, counters, delayed column strobe and the done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      pix_cnt      <= {PIX_W{1'b0}};
      drain_cnt    <= {DR_W{1'b0}};
      ch_cnt       <= {CH_W{1'b0}};
      num_ch       <= {CH_W{1'b0}};
      side_control <= {COL_N{1'b0}};
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      side_control <= top_control;
      done         <= (state == S_FINISH);
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            // A zero channel count still runs one channel.
            num_ch <= (cfg_num_ch == {CH_W{1'b0}}) ? CH_W'(1) : cfg_num_ch;
            ch_cnt <= {CH_W{1'b0}};
          end
        end
        S_LOAD_W: begin
          pix_cnt   <= {PIX_W{1'b0}};
          drain_cnt <= {DR_W{1'b0}};
        end
        S_STREAM:  if (beat) pix_cnt <= pix_cnt + PIX_W'(1);
        S_DRAIN:   drain_cnt <= drain_cnt + DR_W'(1);
        S_NEXT_CH: ch_cnt <= ch_next;
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_xnor_conv_ctrl.sv
// Self-checking bench for xnor_conv_ctrl with a cycle-level behavioural model
// and directed layer scenarios.
module tb_xnor_conv_ctrl;

  localparam int IMG = 16;
  localparam int LAT = 4;
  localparam int CW  = 9;
  localparam int P_I = 0, P_W = 1, P_S = 2, P_D = 3, P_N = 4, P_F = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_start = 1'b0;
  logic [CW-1:0] cfg_num_ch = '0;
  logic          w_valid = 1'b0;
  logic          px_valid = 1'b0;
  logic          w_ready, px_ready, first_channel, last_channel, start;
  logic          weight_control, start_threshold, busy, done;
  logic [8:0]    top_start, top_control, side_control;

  xnor_conv_ctrl #(.IMG_PIX(IMG), .ARRAY_LAT(LAT), .CH_W(CW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_ch(cfg_num_ch),
    .w_valid(w_valid), .w_ready(w_ready), .px_valid(px_valid), .px_ready(px_ready),
    .first_channel(first_channel), .last_channel(last_channel), .start(start),
    .weight_control(weight_control), .start_threshold(start_threshold),
    .top_start(top_start), .top_control(top_control), .side_control(side_control),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Event counters and logs filled by the compare process.
  int cyc = 0, n_start = 0, n_wc = 0, n_done = 0;
  int n_first = 0, n_last = 0, n_both = 0, n_tsnz = 0;
  int last_beat_cyc = 0, done_cyc = 0;
  logic [8:0] beat_log [$];

  // Behavioural model plus per-cycle comparison, sampled on the falling edge.
  initial begin
    int m_ph, m_ch, m_nch, m_b, m_d;
    logic [8:0] m_prev_top, e_top, e_ts, one;
    logic m_done, e_beat, e_layer, e_first, e_last;
    m_ph = P_I; m_ch = 0; m_nch = 1; m_b = 0; m_d = 0;
    m_prev_top = 9'h000; m_done = 1'b0; one = 9'h001;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        m_ph = P_I; m_prev_top = 9'h000; m_done = 1'b0;
      end
      e_beat  = (m_ph == P_S) && px_valid;
      e_top   = e_beat ? (one << (m_b % 9)) : 9'h000;
      e_ts    = (e_beat && m_b < 9) ? e_top : 9'h000;
      e_layer = (m_ph == P_W) || (m_ph == P_S) || (m_ph == P_D);
      e_first = e_layer && (m_ch == 0);
      e_last  = e_layer && (m_ch == m_nch - 1);
      check("busy",            busy,            (m_ph != P_I));
      check("w_ready",         w_ready,         (m_ph == P_W));
      check("px_ready",        px_ready,        (m_ph == P_S));
      check("weight_control",  weight_control,  (m_ph == P_W) && w_valid);
      check("start",           start,           e_beat);
      check("top_control",     top_control,     e_top);
      check("top_start",       top_start,       e_ts);
      check("side_control",    side_control,    m_prev_top);
      check("first_channel",   first_channel,   e_first);
      check("last_channel",    last_channel,    e_last);
      check("start_threshold", start_threshold, e_last && (m_ph == P_S || m_ph == P_D));
      check("done",            done,            m_done);
      check("ready_exclusive", w_ready & px_ready, 1'b0);
      if (start === 1'b1) begin n_start++; last_beat_cyc = cyc; beat_log.push_back(top_control); end
      if (weight_control === 1'b1) n_wc++;
      if (done === 1'b1) begin n_done++; done_cyc = cyc; end
      if (first_channel === 1'b1) n_first++;
      if (last_channel === 1'b1) n_last++;
      if (first_channel === 1'b1 && last_channel === 1'b1) n_both++;
      if (|top_start) n_tsnz++;
      if (rst) begin
        m_prev_top = e_top;
        m_done = (m_ph == P_F);
        case (m_ph)
          P_I: if (cfg_start) begin
                 m_ph = P_W; m_ch = 0;
                 m_nch = (cfg_num_ch == 0) ? 1 : int'(cfg_num_ch);
               end
          P_W: if (w_valid) begin m_ph = P_S; m_b = 0; end
          P_S: if (e_beat) begin
                 m_b++;
                 if (m_b == IMG) begin m_ph = P_D; m_d = 0; end
               end
          P_D: begin m_d++; if (m_d == LAT + 2) m_ph = P_N; end
          P_N: begin m_ch++; m_ph = (m_ch == m_nch) ? P_F : P_W; end
          default: m_ph = P_I;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_layer(input int nch, input bit toggle, input int bound);
    int base;
    base = n_done;
    cfg_num_ch = CW'(nch);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < bound && n_done == base; i++) begin
      if (toggle) px_valid = ~px_valid;
      tick();
    end
    check("layer_done_seen", (n_done != base), 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_start, b_wc, b_done, b_first, b_last, b_both, b_tsnz, b_log, len;
    logic [8:0] exp_tc [10];
    exp_tc = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h010,
               9'h020, 9'h040, 9'h080, 9'h100, 9'h001};

    // Reset state
    w_valid = 1'b1; px_valid = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_top_control", top_control, 9'h000);
    tick();
    rst = 1'b1;
    tick();

    // One channel, continuous pixels
    b_start = n_start; b_wc = n_wc; b_both = n_both;
    run_layer(1, 1'b0, 200);
    check("one_ch_starts", n_start - b_start, 16);
    check("one_ch_wc", n_wc - b_wc, 1);
    check("one_ch_done_latency", done_cyc - last_beat_cyc, LAT + 2 + 3);
    check("one_ch_both_qual_cycles", n_both - b_both, 23);

    // Three channels
    b_start = n_start; b_wc = n_wc; b_done = n_done;
    b_first = n_first; b_last = n_last; b_both = n_both;
    run_layer(3, 1'b0, 400);
    check("three_ch_wc", n_wc - b_wc, 3);
    check("three_ch_starts", n_start - b_start, 48);
    check("three_ch_first_cycles", n_first - b_first, 23);
    check("three_ch_last_cycles", n_last - b_last, 23);
    check("three_ch_both_cycles", n_both - b_both, 0);
    check("three_ch_done", n_done - b_done, 1);

    // Toggling pixel valid: column pointer sequence
    px_valid = 1'b0;
    b_log = beat_log.size(); b_tsnz = n_tsnz;
    run_layer(1, 1'b1, 400);
    px_valid = 1'b1;
    len = beat_log.size() - b_log;
    check("toggle_beats", len, 16);
    for (int i = 0; i < 10; i++) begin
      if (i < len) check($sformatf("toggle_top_control_%0d", i), beat_log[b_log + i], exp_tc[i]);
    end
    check("toggle_top_start_beats", n_tsnz - b_tsnz, 9);

    // Reset during channel 1 streaming
    b_wc = n_wc;
    cfg_num_ch = CW'(3); cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    for (int i = 0; i < 200 && (n_wc - b_wc) < 2; i++) tick();
    check("ch1_reached", n_wc - b_wc, 2);
    repeat (3) tick();
    check("ch1_streaming", px_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_px_ready", px_ready, 1'b0);
    check("abort_top_control", top_control, 9'h000);
    check("abort_side_control", side_control, 9'h000);
    check("abort_start", start, 1'b0);
    tick(); tick();
    rst = 1'b1;
    repeat (3) tick();
    check("abort_stays_idle", busy, 1'b0);
    b_done = n_done;
    cfg_num_ch = CW'(2); cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    check("restart_first_channel", first_channel, 1'b1);
    for (int i = 0; i < 300 && n_done == b_done; i++) tick();
    check("restart_done", n_done - b_done, 1);

    // cfg_start during drain is ignored
    b_start = n_start; b_done = n_done; b_wc = n_wc;
    cfg_num_ch = CW'(1); cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    for (int i = 0; i < 100 && (n_start - b_start) < 16; i++) tick();
    cfg_num_ch = CW'(5); cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    for (int i = 0; i < 50 && n_done == b_done; i++) tick();
    repeat (20) tick();
    check("drain_start_done_count", n_done - b_done, 1);
    check("drain_start_wc", n_wc - b_wc, 1);
    check("drain_start_idle", busy, 1'b0);

    // Zero channel count behaves as one
    b_start = n_start; b_done = n_done; b_wc = n_wc;
    run_layer(0, 1'b0, 200);
    repeat (10) tick();
    check("zero_ch_done", n_done - b_done, 1);
    check("zero_ch_starts", n_start - b_start, 16);
    check("zero_ch_wc", n_wc - b_wc, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
